msi_bus_arbiter: RTL and testbench

MSI_BUS_ARBITER -- requirements
Module: msi_bus_arbiter

---
 rtl/msi_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_msi_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msi_bus_arbiter.sv
// Snoop-bus arbiter for MSI coherent data caches: round-robin grant, one-cycle snoop
// broadcast, optional dirty-holder flush, memory access and completion with timeout.
module msi_bus_arbiter #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CORES-1:0]                req_i,
  input  logic [NUM_CORES-1:0][1:0]           req_type_i,
  input  logic [NUM_CORES-1:0][ADDR_W-1:0]    req_addr_i,
  output logic [NUM_CORES-1:0]                gnt_o,
  output logic                                bus_valid_o,
  output logic [1:0]                          bus_type_o,
  output logic [ADDR_W-1:0]                   bus_addr_o,
  output logic [$clog2(NUM_CORES)-1:0]        bus_src_o,
  input  logic [NUM_CORES-1:0]                snoop_dirty_i,
  input  logic                                flush_done_i,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  input  logic                                mem_ready_i,
  output logic [NUM_CORES-1:0]                done_o,
  output logic                                err_o,
  output logic [15:0]                         txn_cnt_o
);

  localparam int unsigned SRC_W = $clog2(NUM_CORES);
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT - 1);
  localparam logic [1:0] TypeUpgr = 2'b10;
  localparam logic [1:0] TypeWb   = 2'b11;

  typedef enum logic [2:0] {StIdle, StSnoop, StFlush, StMem, StDone} state_e;

  state_e               state_q, state_d;
  logic [SRC_W-1:0]     rr_q, owner_q;
  logic [1:0]           type_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic                 err_q, err_d;
  logic [15:0]          txn_cnt_q;

  logic                 pick_valid;
  logic [SRC_W-1:0]     pick_idx, cand;
  logic [NUM_CORES-1:0] owner_oh;
  logic                 dirty, grant;

  // Search starts one past the last owner so every requester is served in turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      cand = SRC_W'((32'(rr_q) + i) % NUM_CORES);
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  assign dirty = |(snoop_dirty_i & ~owner_oh);
  assign grant = (state_q == StIdle) && pick_valid;

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (pick_valid) state_d = StSnoop;
      end
      StSnoop: begin
        to_cnt_d = '0;
        if (dirty && type_q != TypeWb) state_d = StFlush;
        else if (type_q == TypeUpgr)   state_d = StDone;
        else                           state_d = StMem;
      end
      StFlush: begin
        if (flush_done_i) begin
          to_cnt_d = '0;
          state_d  = (type_q == TypeUpgr) ? StDone : StMem;
        end else if (to_cnt_q == ToLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StMem: begin
        if (mem_ready_i) begin
          state_d = StDone;
        end else if (to_cnt_q == ToLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rr_q      <= SRC_W'(NUM_CORES - 1);
      owner_q   <= '0;
      type_q    <= '0;
      addr_q    <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
      txn_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
      if (grant) begin
        rr_q    <= pick_idx;
        owner_q <= pick_idx;
        type_q  <= req_type_i[pick_idx];
        addr_q  <= req_addr_i[pick_idx];
      end
      if (state_q == StDone && !err_q && txn_cnt_q != 16'hFFFF) begin
        txn_cnt_q <= txn_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    gnt_o       = '0;
    done_o      = '0;
    bus_valid_o = (state_q == StSnoop);
    mem_req_o   = (state_q == StMem);
    mem_we_o    = (state_q == StMem) && (type_q == TypeWb);
    err_o       = (state_q == StDone) && err_q;
    if (state_q == StSnoop || state_q == StFlush || state_q == StMem) gnt_o = owner_oh;
    if (state_q == StDone) done_o = owner_oh;
  end

  assign bus_type_o = type_q;
  assign bus_addr_o = addr_q;
  assign bus_src_o  = owner_q;
  assign txn_cnt_o  = txn_cnt_q;

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Directed bench for msi_bus_arbiter: expected completions go into a queue and a
// monitor process checks each done_o pulse against it.
module tb_msi_bus_arbiter;

  localparam logic [1:0] RD = 2'b00, RDX = 2'b01, UPGR = 2'b10, WB = 2'b11;

  logic             clk, rst;
  logic [1:0]       req;
  logic [1:0][1:0]  req_type;
  logic [1:0][31:0] req_addr;
  logic [1:0]       gnt;
  logic             bus_valid;
  logic [1:0]       bus_type;
  logic [31:0]      bus_addr;
  logic [0:0]       bus_src;
  logic [1:0]       snoop_dirty;
  logic             flush_done;
  logic             mem_req, mem_we, mem_ready;
  logic [1:0]       done;
  logic             err;
  logic [15:0]      txn_cnt;

  msi_bus_arbiter #(.NUM_CORES(2), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_i(req), .req_type_i(req_type), .req_addr_i(req_addr),
    .gnt_o(gnt), .bus_valid_o(bus_valid), .bus_type_o(bus_type), .bus_addr_o(bus_addr),
    .bus_src_o(bus_src), .snoop_dirty_i(snoop_dirty), .flush_done_i(flush_done),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_ready_i(mem_ready), .done_o(done),
    .err_o(err), .txn_cnt_o(txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  done;
    logic        err;
    logic        src;
    logic [1:0]  typ;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   bus_valid_cycles = 0, mem_req_cycles = 0, exp_txn = 0;
  bit   mem_we_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor samples on the falling edge; directed code acts 1ns later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("gnt onehot0", 64'($onehot0(gnt)), 1);
      if (bus_valid) bus_valid_cycles++;
      if (mem_req) mem_req_cycles++;
      if (mem_we) mem_we_seen = 1;
      if (done != 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected done: got %b expected none", done);
        end else begin
          e = exp_q.pop_front();
          check("done owner", done, e.done);
          check("err flag", err, e.err);
          check("bus src", bus_src, e.src);
          check("bus type", bus_type, e.typ);
          check("bus addr", bus_addr, e.addr);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counters();
    bus_valid_cycles = 0;
    mem_req_cycles   = 0;
    mem_we_seen      = 0;
  endtask

  task automatic push_exp(input int core, input logic [1:0] t, input logic [31:0] a,
                          input logic e);
    exp_t x;
    x.done = 2'(1 << core);
    x.err  = e;
    x.src  = 1'(core);
    x.typ  = t;
    x.addr = a;
    exp_q.push_back(x);
    if (!e) exp_txn++;
  endtask

  task automatic issue(input int core, input logic [1:0] t, input logic [31:0] a,
                       input logic e);
    req_type[core] = t;
    req_addr[core] = a;
    req[core]      = 1'b1;
    push_exp(core, t, a, e);
  endtask

  task automatic drop_on_done(input int core);
    int n = 0;
    while (done[core] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check($sformatf("done reached core%0d", core), done[core], 1);
    req[core] = 1'b0;
  endtask

  task automatic wait_mem();
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("mem_req reached", mem_req, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0; req_type = '0; req_addr = '0;
    snoop_dirty = '0; flush_done = 1'b0; mem_ready = 1'b0;
    step();
    step();
    check("reset gnt", gnt, 0);
    check("reset bus_valid", bus_valid, 0);
    check("reset mem", {mem_req, mem_we}, 0);
    check("reset done/err", {done, err}, 0);
    check("reset txn_cnt", txn_cnt, 0);
    check("reset bus fields", {bus_type, bus_addr, bus_src}, 0);
    exp_txn = 0;
    rst = 1'b1;
    step();
  endtask

  initial begin
    int n;
    do_reset();

    // Single BusRd, memory answers in the third MEM cycle.
    clear_counters();
    issue(0, RD, 32'h1000, 1'b0);
    step();
    check("rd gnt", gnt, 2'b01);
    wait_mem();
    step();
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    drop_on_done(0);
    step();
    check("rd txn_cnt", txn_cnt, 16'(exp_txn));
    check("rd mem_req cycles", mem_req_cycles, 3);
    check("rd bus_valid cycles", bus_valid_cycles, 1);

    // Round-robin ties after reset.
    do_reset();
    issue(0, UPGR, 32'h0100, 1'b0);
    issue(1, UPGR, 32'h0200, 1'b0);
    step();
    check("tie1 gnt core0", gnt, 2'b01);
    drop_on_done(0);
    step();
    check("tie1 idle gnt", gnt, 2'b00);
    step();
    check("tie1 gnt core1", gnt, 2'b10);
    drop_on_done(1);
    step();
    issue(0, UPGR, 32'h0300, 1'b0);
    issue(1, UPGR, 32'h0400, 1'b0);
    step();
    check("tie2 gnt core0", gnt, 2'b01);
    drop_on_done(0);
    step();
    step();
    check("tie2 gnt core1", gnt, 2'b10);
    drop_on_done(1);
    step();
    check("tie txn_cnt", txn_cnt, 16'(exp_txn));

    // BusRdX with core0 dirty: FLUSH then MEM; stray mem_ready in FLUSH is ignored.
    clear_counters();
    issue(1, RDX, 32'h2040, 1'b0);
    snoop_dirty = 2'b01;
    step();
    step();
    check("flush no mem_req", mem_req, 0);
    check("flush gnt", gnt, 2'b10);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("flush still waiting", {mem_req, done}, 0);
    flush_done = 1'b1;
    step();
    flush_done  = 1'b0;
    snoop_dirty = 2'b00;
    check("mem after flush", mem_req, 1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    drop_on_done(1);
    step();

    // BusUpgr; owner's own dirty bit does not force a flush.
    clear_counters();
    issue(0, UPGR, 32'h3000, 1'b0);
    snoop_dirty = 2'b01;
    n = 0;
    while (done == 2'b00 && n < 20) begin
      step();
      n++;
    end
    check("upgr done latency", n, 2);
    snoop_dirty = 2'b00;
    req[0] = 1'b0;
    step();
    check("upgr no mem_req", mem_req_cycles, 0);

    // WriteBack with memory never ready: timeout error.
    clear_counters();
    issue(0, WB, 32'h4000, 1'b1);
    drop_on_done(0);
    step();
    check("wb mem_we seen", mem_we_seen, 1);
    check("wb timeout window", 64'(mem_req_cycles >= 8 && mem_req_cycles <= 9), 1);
    check("wb txn_cnt unchanged", txn_cnt, 16'(exp_txn));

    // Reset during MEM aborts; the still-pending request is granted again.
    clear_counters();
    req_type[1] = RD;
    req_addr[1] = 32'h5000;
    req[1]      = 1'b1;
    step();
    wait_mem();
    step();
    rst = 1'b0;
    #1;
    check("abort gnt", gnt, 0);
    check("abort mem", {mem_req, mem_we}, 0);
    check("abort done", {done, err}, 0);
    check("abort txn_cnt", txn_cnt, 0);
    check("abort bus addr", bus_addr, 0);
    exp_txn = 0;
    step();
    step();
    push_exp(1, RD, 32'h5000, 1'b0);
    rst = 1'b1;
    step();
    check("regrant core1", gnt, 2'b10);
    wait_mem();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    drop_on_done(1);
    step();
    check("regrant txn_cnt", txn_cnt, 16'(exp_txn));

    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
